// File: rtl/mbr_unit_pkg.sv
// Shared definitions for the memory buffer register unit.
//  - mbr_state_e : transaction FSM state encoding (2-bit)
//  - MbrDataW / MbrTimeout : default data width and wait-state limit
//  - cnt_width() : wait counter width for a given limit (minimum 1 bit)
package mbr_unit_pkg;

  typedef enum logic [1:0] {
    MBR_IDLE    = 2'd0,
    MBR_RD_WAIT = 2'd1,
    MBR_WR_WAIT = 2'd2
  } mbr_state_e;

  localparam int unsigned MbrDataW   = 16;
  localparam int unsigned MbrTimeout = 15;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mbr_unit_if.sv
// Memory-side request/acknowledge bus of the MBR unit.
//  mem_req   : request held until ack or timeout (driven by master)
//  mem_we    : 1 = write, valid while mem_req (master)
//  mem_wdata : write data, equals MBR (master)
//  mem_rdata : read data, valid with mem_ack (slave)
//  mem_ack   : memory completes the current request (slave)
interface mbr_unit_if #(
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mbr_wait_timer.sv
// Wait-state counter for the MBR transaction FSM.
//  i_clk, i_rst : clock, asynchronous active-high reset
//  i_clr        : clear counter (held while the FSM is idle)
//  i_en         : count one wait cycle
//  o_expire     : counter is on its last allowed cycle (never set when TIMEOUT = 0)
module mbr_wait_timer
  import mbr_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = MbrTimeout
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (TIMEOUT != 0) && (cnt_q == CntLast);

endmodule

// File: rtl/mbr_unit.sv
// Memory buffer register with prioritised datapath loads, gated sinks and its own
// req/ack memory transaction FSM with wait-state timeout.
//  i_clk, i_rst    : clock, asynchronous active-high reset
//  i_src_data/ld   : NSRC load sources (index 0 highest priority), IDLE only
//  i_rd_req/wr_req : start memory read into / write of MBR (read wins)
//  i_dst_oe        : per-sink enable; o_dst_data sink j = oe[j] ? MBR : 0
//  o_mbr           : raw MBR
//  o_busy          : transaction in progress
//  o_done/timeout  : 1-cycle completion / abandonment pulses
//  mem             : memory request bus (master side)
module mbr_unit
  import mbr_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = MbrDataW,
  parameter int unsigned NSRC    = 4,
  parameter int unsigned NDST    = 5,
  parameter int unsigned TIMEOUT = MbrTimeout
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NSRC*DATA_W-1:0] i_src_data,
  input  logic [NSRC-1:0]        i_src_ld,
  input  logic                   i_rd_req,
  input  logic                   i_wr_req,
  input  logic [NDST-1:0]        i_dst_oe,
  output logic [NDST*DATA_W-1:0] o_dst_data,
  output logic [DATA_W-1:0]      o_mbr,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout,
  mbr_unit_if.master             mem
);

  mbr_state_e        state_d, state_q;
  logic [DATA_W-1:0] mbr_d, mbr_q;
  logic              done_d, done_q;
  logic              timeout_d, timeout_q;
  logic              expire;

  logic [DATA_W-1:0] src_arr [NSRC];
  logic              ld_any;
  logic [DATA_W-1:0] ld_val;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign src_arr[k] = i_src_data[k*DATA_W +: DATA_W];
  end

  // First asserted strobe from index 0 upward wins.
  always_comb begin
    ld_any = 1'b0;
    ld_val = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      if (i_src_ld[k] && !ld_any) begin
        ld_any = 1'b1;
        ld_val = src_arr[k];
      end
    end
  end

  mbr_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (state_q == MBR_IDLE),
    .i_en     (!mem.mem_ack),
    .o_expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    mbr_d     = mbr_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      MBR_IDLE: begin
        if (ld_any) begin
          mbr_d = ld_val;
        end
        if (i_rd_req) begin
          state_d = MBR_RD_WAIT;
        end else if (i_wr_req) begin
          state_d = MBR_WR_WAIT;
        end
      end
      MBR_RD_WAIT: begin
        // Ack on the expiry cycle takes precedence over the timeout.
        if (mem.mem_ack) begin
          mbr_d   = mem.mem_rdata;
          done_d  = 1'b1;
          state_d = MBR_IDLE;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = MBR_IDLE;
        end
      end
      MBR_WR_WAIT: begin
        if (mem.mem_ack) begin
          done_d  = 1'b1;
          state_d = MBR_IDLE;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = MBR_IDLE;
        end
      end
      default: state_d = MBR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= MBR_IDLE;
      mbr_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mbr_q     <= mbr_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  for (genvar j = 0; j < NDST; j++) begin : g_dst
    assign o_dst_data[j*DATA_W +: DATA_W] = i_dst_oe[j] ? mbr_q : '0;
  end

  assign o_mbr         = mbr_q;
  assign o_busy        = (state_q != MBR_IDLE);
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign mem.mem_req   = (state_q != MBR_IDLE);
  assign mem.mem_we    = (state_q == MBR_WR_WAIT);
  assign mem.mem_wdata = mbr_q;

endmodule

// File: tb/tb_mbr_unit.sv
// Self-checking bench for mbr_unit: directed scenarios plus randomized loads and
// transactions checked against a transaction-level reference model.
module tb_mbr_unit;
  localparam int unsigned DW = 16;
  localparam int unsigned NS = 4;
  localparam int unsigned ND = 5;
  localparam int unsigned TO = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NS*DW-1:0] src_data = '0;
  logic [NS-1:0]    src_ld = '0;
  logic             rd_req = 1'b0;
  logic             wr_req = 1'b0;
  logic [ND-1:0]    dst_oe = '0;
  logic [ND*DW-1:0] dst_data;
  logic [DW-1:0]    mbr;
  logic             busy, done, tmo;

  mbr_unit_if #(.DATA_W(DW)) mem_if ();

  mbr_unit #(
    .DATA_W  (DW),
    .NSRC    (NS),
    .NDST    (ND),
    .TIMEOUT (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_src_data (src_data),
    .i_src_ld   (src_ld),
    .i_rd_req   (rd_req),
    .i_wr_req   (wr_req),
    .i_dst_oe   (dst_oe),
    .o_dst_data (dst_data),
    .o_mbr      (mbr),
    .o_busy     (busy),
    .o_done     (done),
    .o_timeout  (tmo),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] exp_mbr = '0;

  // Reference: value held by the register after a load request with this strobe set.
  function automatic logic [DW-1:0] ref_load(input logic [NS-1:0] ld, input logic [NS*DW-1:0] src,
                                             input logic [DW-1:0] cur);
    for (int k = 0; k < int'(NS); k++) begin
      if (ld[k]) return src[k*DW +: DW];
    end
    return cur;
  endfunction

  function automatic logic [ND*DW-1:0] ref_sinks(input logic [ND-1:0] oe, input logic [DW-1:0] v);
    logic [ND*DW-1:0] r;
    r = '0;
    for (int j = 0; j < int'(ND); j++) begin
      if (oe[j]) r[j*DW +: DW] = v;
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    dst_oe = '1;
    #1;
    checks++; if (mbr !== 16'h0000) begin errors++; $display("FAIL rst_mbr got %h want 0000", mbr); end
    checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b%b want 00", mem_if.mem_req, mem_if.mem_we); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || tmo !== 1'b0) begin
      errors++; $display("FAIL rst_flags got %b%b%b want 000", busy, done, tmo); end
    checks++; if (dst_data !== '0) begin errors++; $display("FAIL rst_dst got %h want 0", dst_data); end
    @(posedge clk); #1 rst = 1'b0;
    cyc();
    // Reset in the middle of a read.
    src_data[15:0] = 16'h0077; src_ld = 4'b0001; rd_req = 1'b1;
    cyc();
    src_ld = '0; rd_req = 1'b0;
    checks++; if (mbr !== 16'h0077 || mem_if.mem_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got mbr=%h req=%b want 0077 1", mbr, mem_if.mem_req); end
    cyc();
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_if.mem_req !== 1'b0 || busy !== 1'b0 || mbr !== 16'h0000 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid got req=%b busy=%b mbr=%h done=%b want 0 0 0000 0",
                         mem_if.mem_req, busy, mbr, done); end
    @(posedge clk); #1 rst = 1'b0;
    exp_mbr = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (done !== 1'b0 || tmo !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_after got %b%b%b want 000", done, tmo, busy); end
    end
  endtask

  task automatic test_priority();
    src_data = '0;
    src_data[1*DW +: DW] = 16'h00A5;
    src_data[2*DW +: DW] = 16'h1234;
    src_ld = 4'b0110; dst_oe = 5'b00100;
    exp_mbr = ref_load(src_ld, src_data, exp_mbr);
    cyc();
    src_ld = '0;
    checks++; if (mbr !== exp_mbr) begin errors++; $display("FAIL prio_mbr got %h want %h", mbr, exp_mbr); end
    checks++; if (dst_data !== ref_sinks(dst_oe, exp_mbr)) begin
      errors++; $display("FAIL prio_dst got %h want %h", dst_data, ref_sinks(dst_oe, exp_mbr)); end
    for (int n = 0; n < 20; n++) begin
      src_data = {$urandom, $urandom};
      src_ld   = NS'($urandom_range(0, 15));
      dst_oe   = ND'($urandom_range(0, 31));
      exp_mbr  = ref_load(src_ld, src_data, exp_mbr);
      cyc();
      src_ld = '0;
      checks++; if (mbr !== exp_mbr) begin
        errors++; $display("FAIL rload_mbr got %h want %h", mbr, exp_mbr); end
      checks++; if (dst_data !== ref_sinks(dst_oe, exp_mbr)) begin
        errors++; $display("FAIL rload_dst got %h want %h", dst_data, ref_sinks(dst_oe, exp_mbr)); end
    end
  endtask

  // One transaction from IDLE; ack arrives on wait cycle w (never if w >= TO).
  task automatic run_txn(input bit do_rd, input bit do_wr, input int w, input logic [DW-1:0] rdv);
    bit is_wr;
    bit fin;
    is_wr = !do_rd && do_wr;
    rd_req = do_rd; wr_req = do_wr;
    cyc();
    rd_req = 1'b0; wr_req = 1'b0;
    checks++; if (mem_if.mem_we !== is_wr) begin
      errors++; $display("FAIL txn_we got %b want %b", mem_if.mem_we, is_wr); end
    if (is_wr) begin
      checks++; if (mem_if.mem_wdata !== exp_mbr) begin
        errors++; $display("FAIL txn_wdata got %h want %h", mem_if.mem_wdata, exp_mbr); end
    end
    fin = 1'b0;
    for (int i = 0; i < int'(TO) && !fin; i++) begin
      checks++; if (mem_if.mem_req !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL txn_req cyc %0d got %b%b want 11", i, mem_if.mem_req, busy); end
      mem_if.mem_ack   = (i == w);
      mem_if.mem_rdata = (i == w) ? rdv : DW'($urandom);
      // Strobes during a transaction must be ignored.
      src_data = {$urandom, $urandom};
      src_ld   = NS'($urandom_range(0, 15));
      rd_req   = 1'($urandom_range(0, 1));
      wr_req   = 1'($urandom_range(0, 1));
      cyc();
      mem_if.mem_ack = 1'b0; src_ld = '0; rd_req = 1'b0; wr_req = 1'b0;
      if (i == w) begin
        if (!is_wr) exp_mbr = rdv;
        fin = 1'b1;
        checks++; if (done !== 1'b1 || tmo !== 1'b0 || mem_if.mem_req !== 1'b0) begin
          errors++; $display("FAIL txn_done got d=%b t=%b req=%b want 1 0 0", done, tmo, mem_if.mem_req);
        end
      end else if (i == int'(TO) - 1) begin
        fin = 1'b1;
        checks++; if (tmo !== 1'b1 || done !== 1'b0 || mem_if.mem_req !== 1'b0) begin
          errors++; $display("FAIL txn_tmo got t=%b d=%b req=%b want 1 0 0", tmo, done, mem_if.mem_req);
        end
      end else begin
        checks++; if (done !== 1'b0 || tmo !== 1'b0) begin
          errors++; $display("FAIL txn_early cyc %0d got d=%b t=%b want 0 0", i, done, tmo); end
      end
      checks++; if (mbr !== exp_mbr) begin
        errors++; $display("FAIL txn_mbr got %h want %h", mbr, exp_mbr); end
    end
    cyc();
    checks++; if (done !== 1'b0 || tmo !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL txn_pulse got d=%b t=%b b=%b want 0 0 0", done, tmo, busy); end
  endtask

  task automatic test_read();
    run_txn(1'b1, 1'b0, 2, 16'hBEEF);
    checks++; if (mbr !== 16'hBEEF) begin errors++; $display("FAIL read_mbr got %h want BEEF", mbr); end
  endtask

  task automatic test_write_load();
    src_data = '0;
    src_data[3*DW +: DW] = 16'h5A5A;
    src_data[0 +: DW]    = 16'h1111;
    src_ld = 4'b1000; wr_req = 1'b1;
    exp_mbr = ref_load(src_ld, src_data, exp_mbr);
    cyc();
    src_ld = '0; wr_req = 1'b0;
    checks++; if (mem_if.mem_we !== 1'b1 || mem_if.mem_req !== 1'b1 || mem_if.mem_wdata !== exp_mbr) begin
      errors++; $display("FAIL wr_start got we=%b req=%b wd=%h want 1 1 %h",
                         mem_if.mem_we, mem_if.mem_req, mem_if.mem_wdata, exp_mbr); end
    src_data[0 +: DW] = 16'hFFFF; src_ld = 4'b0001;
    cyc();
    src_ld = '0;
    checks++; if (mbr !== exp_mbr || mem_if.mem_wdata !== exp_mbr) begin
      errors++; $display("FAIL wr_ignld got mbr=%h wd=%h want %h", mbr, mem_if.mem_wdata, exp_mbr); end
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hDEAD;
    cyc();
    mem_if.mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || mbr !== exp_mbr || mem_if.mem_req !== 1'b0) begin
      errors++; $display("FAIL wr_done got d=%b mbr=%h req=%b want 1 %h 0",
                         done, mbr, mem_if.mem_req, exp_mbr); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b want 0", done); end
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 100, 16'h0BAD);
    run_txn(1'b1, 1'b0, int'(TO) - 1, 16'hC0DE);
    run_txn(1'b0, 1'b1, 100, 16'h0000);
  endtask

  task automatic test_both_and_stray();
    run_txn(1'b1, 1'b1, int'($urandom_range(0, 5)), DW'($urandom));
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = ~exp_mbr;
    cyc();
    mem_if.mem_ack = 1'b0;
    cyc();
    checks++; if (mbr !== exp_mbr || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stray_ack got mbr=%h d=%b b=%b want %h 0 0", mbr, done, busy, exp_mbr); end
  endtask

  task automatic test_random_txn();
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        src_data = {$urandom, $urandom};
        src_ld   = NS'($urandom_range(1, 15));
        exp_mbr  = ref_load(src_ld, src_data, exp_mbr);
      end
      run_txn(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 18)), DW'($urandom));
    end
  endtask

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    test_reset();
    test_priority();
    test_read();
    test_write_load();
    test_timeout();
    test_both_and_stray();
    test_random_txn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
